dram_arbiter: RTL
=================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, is the data and address width of each core port and of the RAM port.
REQ-002 Parameter NCORES, default 4 (legal 2..8), is the number of requesting cores.
REQ-003 Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 memREAD  input  NCORES  per-core read request, level, held until that core's memAV.
REQ-006 memWRITE  input  NCORES  per-core write request, level, held until that core's memAV.
REQ-007 DRAM_addr  input  NCORES*WIDTH  per-core address; core i occupies bits [i*WIDTH +: WIDTH].
REQ-008 DRAM_dataOut  input  NCORES*WIDTH  per-core write data, same slicing.
REQ-009 DRAM_dataIn  output  NCORES*WIDTH  per-core registered read data, same slicing.
REQ-010 memAV  output  NCORES  per-core one-cycle completion pulse.
REQ-011 coreS  input  NCORES  per-core done status.
REQ-012 allDone  output  1  registered AND of coreS.
REQ-013 ram_addr  output  WIDTH  address to the single-port synchronous RAM.
REQ-014 ram_wdata  output  WIDTH  write data to the RAM.
REQ-015 ram_we / ram_re  output  1 each  RAM write / read strobes.
REQ-016 ram_rdata  input  WIDTH  RAM read data, valid one cycle after ram_re.
REQ-017 grantID  output  3  index of the currently granted core; busy  output  1  high when state is not IDLE.

Function
REQ-018 The FSM has exactly three states: IDLE, ACCESS and RESP.
REQ-019 In IDLE, with any request bit high at a rising edge: register the winner, its address, its write data and its op; go to ACCESS.
REQ-020 Winner selection is round-robin: search starts at (last granted + 1) mod NCORES; after reset the pointer is NCORES-1, so core 0 has first priority.
REQ-021 If one core asserts memREAD and memWRITE together, the access is a write.
REQ-022 In ACCESS, ram_addr shows the latched address; a write asserts ram_we with ram_wdata, and a read asserts ram_re; next state is RESP.
REQ-023 In RESP, memAV[grantID] is 1 for exactly one cycle.
REQ-024 In RESP on a read, ram_rdata is captured into that core's DRAM_dataIn slice at the end of the cycle; state returns to IDLE.
REQ-025 Latency: a request sampled at edge E gives memAV high in the cycle after edge E+1; one access takes 3 cycles including IDLE.
REQ-026 A core's DRAM_dataIn slice holds its value until that core's next read completes; other slices never change.
REQ-027 Requests are sampled only in IDLE; changes in ACCESS or RESP are ignored.
REQ-028 A core must drop its request the cycle after memAV; a request still high is treated as a new access.
REQ-029 ram_we, ram_re and memAV are never asserted outside ACCESS or RESP as defined above.
REQ-030 allDone is registered and updates every cycle independently of the FSM.

Reset
REQ-031 When Rst_n is low, the block immediately goes to IDLE; memAV, ram_we, ram_re, busy and allDone read 0; DRAM_dataIn, ram_addr, ram_wdata and grantID read 0; the round-robin pointer is NCORES-1.
REQ-032 Reset in ACCESS or RESP drops the access without a memAV pulse; a write already strobed may have completed in the RAM.

Structure
REQ-033 State encodings (IDLE/ACCESS/RESP) and the NCORES default go in the shared proc_param.v include.
REQ-034 Round-robin selection is one sub-module, rr_arbiter: inputs are the request vector and the pointer; outputs are the one-hot grant and the encoded index.

Verification
REQ-035 Single read: core 1 reads addr 0x10 where RAM holds 0xA5 -> ram_re high in the cycle after sampling; memAV[1] pulses on the next cycle; DRAM_dataIn slice 1 = 0xA5.
REQ-036 Write then read: core 2 writes 0x3C to 0x20, then reads 0x20 -> ram_we high with addr 0x20 and data 0x3C; the read returns 0x3C.
REQ-037 Contention: all 4 cores request reads at the same time after reset -> grants go in order 0,1,2,3, 3 cycles apart, with one memAV pulse each.
REQ-038 Fairness: cores 0 and 3 request back-to-back continuously -> grants alternate 0,3,0,3 with no starvation.
REQ-039 Reset mid-access: drop Rst_n during ACCESS of a core 0 read -> no memAV; all outputs are 0 at once; after release, core 0 is again first priority.
REQ-040 Read+write collision and allDone: core 1 asserts both with addr 0x05 and data 0x77 -> a write occurs; with coreS=4'b1111, allDone is 1 one cycle later.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// Shared types and helpers for the multi-core DRAM arbiter.
// Holds the FSM state encoding, the access opcode and the round-robin index wrap.
package dram_arbiter_pkg;

  localparam int unsigned NCORES_DEFAULT = 4;
  localparam int unsigned GRANT_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Core index reached by stepping 'step' places past 'base', wrapping at n.
  function automatic int unsigned wrap_idx(input logic [GRANT_W-1:0] base,
                                           input int unsigned step,
                                           input int unsigned n);
    return (32'(base) + step) % n;
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_arbiter.sv
// Round-robin winner select: the first requester found after the pointer.
// Purely combinational; the caller registers the result.
module dram_arbiter_rr_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned NCORES = NCORES_DEFAULT
) (
  input  logic [NCORES-1:0]  req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NCORES-1:0]  grant_c,
  output logic [GRANT_W-1:0] idx_c,
  output logic               valid_c
);

  // Walk priority positions ptr+1 .. ptr+NCORES; the first hit wins.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    for (int unsigned k = 1; k <= NCORES; k++) begin
      for (int unsigned i = 0; i < NCORES; i++) begin
        if (!valid_c && req[i] && (i == wrap_idx(ptr, k, NCORES))) begin
          valid_c    = 1'b1;
          idx_c      = GRANT_W'(i);
          grant_c[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one single-port synchronous RAM among NCORES cores.
// Each access runs IDLE -> ACCESS -> RESP; all outputs are registered.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NCORES = NCORES_DEFAULT
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [NCORES-1:0]       memREAD,
  input  logic [NCORES-1:0]       memWRITE,
  input  logic [NCORES*WIDTH-1:0] DRAM_addr,
  input  logic [NCORES*WIDTH-1:0] DRAM_dataOut,
  output logic [NCORES*WIDTH-1:0] DRAM_dataIn,
  output logic [NCORES-1:0]       memAV,
  input  logic [NCORES-1:0]       coreS,
  output logic                    allDone,
  output logic [WIDTH-1:0]        ram_addr,
  output logic [WIDTH-1:0]        ram_wdata,
  output logic                    ram_we,
  output logic                    ram_re,
  input  logic [WIDTH-1:0]        ram_rdata,
  output logic [GRANT_W-1:0]      grantID,
  output logic                    busy
);

  state_t             state, state_next;
  op_t                op, op_next;
  logic [NCORES-1:0]  req;
  logic [NCORES-1:0]  win_onehot;
  logic [GRANT_W-1:0] win_idx;
  logic               win_valid;
  logic [GRANT_W-1:0] ptr, ptr_next, grant_next;
  logic [WIDTH-1:0]   addr_sel, wdata_sel, addr_next, wdata_next;
  logic [NCORES-1:0]  av_next, capture;
  logic               we_next, re_next, busy_next;

  assign req = memREAD | memWRITE;

  dram_arbiter_rr_arbiter #(
    .NCORES(NCORES)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (ptr),
    .grant_c(win_onehot),
    .idx_c  (win_idx),
    .valid_c(win_valid)
  );

  // Pick the winning core's address and write data.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (win_onehot[i]) begin
        addr_sel  = DRAM_addr[i*WIDTH +: WIDTH];
        wdata_sel = DRAM_dataOut[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_next = state;
    op_next    = op;
    grant_next = grantID;
    ptr_next   = ptr;
    addr_next  = ram_addr;
    wdata_next = ram_wdata;
    we_next    = 1'b0;
    re_next    = 1'b0;
    av_next    = '0;
    capture    = '0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          state_next = ST_ACCESS;
          grant_next = win_idx;
          ptr_next   = win_idx;
          addr_next  = addr_sel;
          wdata_next = wdata_sel;
          op_next    = |(memWRITE & win_onehot) ? OP_WRITE : OP_READ;
          we_next    = (op_next == OP_WRITE);
          re_next    = (op_next == OP_READ);
        end
      end
      ST_ACCESS: begin
        state_next = ST_RESP;
        for (int unsigned i = 0; i < NCORES; i++) begin
          av_next[i] = (grantID == GRANT_W'(i));
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        for (int unsigned i = 0; i < NCORES; i++) begin
          capture[i] = (op == OP_READ) && (grantID == GRANT_W'(i));
        end
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op          <= OP_READ;
      grantID     <= '0;
      ptr         <= GRANT_W'(NCORES - 1);
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      ram_re      <= 1'b0;
      memAV       <= '0;
      busy        <= 1'b0;
      allDone     <= 1'b0;
      DRAM_dataIn <= '0;
    end else begin
      op        <= op_next;
      grantID   <= grant_next;
      ptr       <= ptr_next;
      ram_addr  <= addr_next;
      ram_wdata <= wdata_next;
      ram_we    <= we_next;
      ram_re    <= re_next;
      memAV     <= av_next;
      busy      <= busy_next;
      allDone   <= &coreS;
      for (int unsigned i = 0; i < NCORES; i++) begin
        if (capture[i]) DRAM_dataIn[i*WIDTH +: WIDTH] <= ram_rdata;
      end
    end
  end

endmodule
